// File: rtl/frankie_isa_pkg.sv
// Frankie ISA definitions shared by the fetch stage.
//   - Opcode constants (OP_APUT..OP_SWAP legal range, reserved SHFL slots, OP_NOP)
//   - Instruction field positions
//   - Fetch FSM state encoding
//   - is_reserved_op(): opcode legality helper, used when IFETCH_ILLEGAL_TRAP_EN is defined
package frankie_isa_pkg;

  // Opcode space: 0..23 are assignable; 17 and 18 are reserved SHFL variants.
  localparam logic [4:0] OP_APUT      = 5'b00000;
  localparam logic [4:0] OP_SHFL_RSV0 = 5'b10001;
  localparam logic [4:0] OP_SHFL_RSV1 = 5'b10010;
  localparam logic [4:0] OP_SWAP      = 5'b10111;
  localparam logic [4:0] OP_NOP       = 5'b11111;

  // Instruction word layout: {opcode[4:0], flag, imm[9:0]}
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned FLAG_BIT = 10;
  localparam int unsigned IMM_W    = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // True for opcodes that must never reach the control unit.
  function automatic logic is_reserved_op(input logic [4:0] opc);
    return (opc > OP_SWAP) || (opc == OP_SHFL_RSV0) || (opc == OP_SHFL_RSV1);
  endfunction

endpackage

// File: rtl/ifetch_ir_split.sv
// Combinational split of the IR into control-unit fields.
// While no instruction is held, presents NOP_OPCODE and zero flag/imm so the
// control unit asserts no write enables.
// Ports:
//   ir          in   16  instruction register
//   ir_valid    in   1   IR holds an instruction being executed
//   illegal     in   1   captured instruction was trapped (IFETCH_ILLEGAL_TRAP_EN only)
//   OPCODE      out  5   IR opcode or NOP_OPCODE
//   flagbit     out  1   IR flag bit or 0
//   imm         out  10  IR immediate or 0
//   illegal_op  out  1   trapped instruction in hold (IFETCH_ILLEGAL_TRAP_EN only)
module ifetch_ir_split
  import frankie_isa_pkg::*;
#(
  parameter logic [4:0] NOP_OPCODE = OP_NOP
) (
  input  logic [15:0]      ir,
  input  logic             ir_valid,
`ifdef IFETCH_ILLEGAL_TRAP_EN
  input  logic             illegal,
  output logic             illegal_op,
`endif
  output logic [4:0]       OPCODE,
  output logic             flagbit,
  output logic [IMM_W-1:0] imm
);

  always_comb begin
    OPCODE  = NOP_OPCODE;
    flagbit = 1'b0;
    imm     = '0;
    if (ir_valid) begin
      OPCODE  = ir[OPC_MSB:OPC_LSB];
      flagbit = ir[FLAG_BIT];
      imm     = ir[IMM_W-1:0];
    end
  end

`ifdef IFETCH_ILLEGAL_TRAP_EN
  assign illegal_op = ir_valid & illegal;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the Frankie CPU.
// Reads one 16-bit instruction at the datapath PC over a req/ack handshake, holds
// it in the IR until exec_done, and retries the same address after ACK_TIMEOUT
// wait cycles without ack (pulsing fetch_err).
// Optional macro IFETCH_ILLEGAL_TRAP_EN: reserved opcodes are replaced by NOP_OPCODE
// on capture and flagged on illegal_op during hold.
// Ports:
//   CLK, reset_n (sync active-low), run, pc[AW], exec_done
//   imem_req, imem_addr[AW], imem_ack, imem_rdata[16]
//   OPCODE[5], flagbit, imm[10], ir_valid, fetch_err, busy, [illegal_op]
module instruction_fetch
  import frankie_isa_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [4:0]  NOP_OPCODE  = OP_NOP
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             run,
  input  logic [AW-1:0]    pc,
  input  logic             exec_done,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic [4:0]       OPCODE,
  output logic             flagbit,
  output logic [IMM_W-1:0] imm,
  output logic             ir_valid,
  output logic             fetch_err,
  output logic             busy
`ifdef IFETCH_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  localparam logic [7:0] TimeoutCnt = 8'(ACK_TIMEOUT);

  fetch_state_e  state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   ir_q, ir_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ir_d      = ir_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_REQ;
          addr_d  = pc;
          cnt_d   = '0;
        end
      end
      S_REQ, S_WAIT: begin
        if (imem_ack) begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          ir_d      = imem_rdata;
          illegal_d = 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
          if (is_reserved_op(imem_rdata[OPC_MSB:OPC_LSB])) begin
            ir_d[OPC_MSB:OPC_LSB] = NOP_OPCODE;
            illegal_d             = 1'b1;
          end
`endif
        end else if (state_q == S_REQ) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end else if (cnt_q == TimeoutCnt) begin
          // Retry the same address; imem_addr is left untouched.
          state_d = S_REQ;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          if (run) begin
            state_d = S_REQ;
            addr_d  = pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ir_q      <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign imem_addr = addr_q;
  assign ir_valid  = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign fetch_err = err_q;

`ifndef IFETCH_ILLEGAL_TRAP_EN
  // Trap flag only feeds illegal_op; without the feature it is constant zero.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

  ifetch_ir_split #(
    .NOP_OPCODE (NOP_OPCODE)
  ) u_ir_split (
    .ir         (ir_q),
    .ir_valid   (ir_valid),
`ifdef IFETCH_ILLEGAL_TRAP_EN
    .illegal    (illegal_q),
    .illegal_op (illegal_op),
`endif
    .OPCODE     (OPCODE),
    .flagbit    (flagbit),
    .imm        (imm)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus with literal expectations, plus a
// transaction-level model (fetching / holding, attempt age) compared every cycle.
module tb_instruction_fetch;

  localparam int unsigned TO = 15;

  logic        CLK;
  logic        reset_n, run, exec_done, imem_ack;
  logic [15:0] pc, imem_rdata;
  logic        imem_req, ir_valid, fetch_err, busy, flagbit;
  logic [15:0] imem_addr;
  logic [4:0]  OPCODE;
  logic [9:0]  imm;
`ifdef IFETCH_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .AW          (16),
    .ACK_TIMEOUT (TO),
    .NOP_OPCODE  (5'b11111)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .run        (run),
    .pc         (pc),
    .exec_done  (exec_done),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .OPCODE     (OPCODE),
    .flagbit    (flagbit),
    .imm        (imm),
    .ir_valid   (ir_valid),
    .fetch_err  (fetch_err),
    .busy       (busy)
`ifdef IFETCH_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request is either outstanding (m_fetching) or an instruction is held.
  // Each request attempt may last TO+1 cycles; when an attempt ends without ack
  // the error pulse shows in the following cycle and a new attempt starts.
  bit          m_fetching = 0;
  bit          m_holding  = 0;
  bit          m_err      = 0;
  bit          m_illegal  = 0;
  int          m_age      = 0;
  logic [15:0] m_addr     = '0;
  logic [15:0] m_ir       = '0;

  always @(posedge CLK) begin
    if (!reset_n) begin
      m_fetching = 0; m_holding = 0; m_err = 0; m_illegal = 0;
      m_age = 0; m_addr = '0; m_ir = '0;
    end else begin
      m_err = 0;
      if (m_holding) begin
        if (exec_done) begin
          m_holding = 0;
          if (run) begin
            m_fetching = 1; m_addr = pc; m_age = 0;
          end
        end
      end else if (m_fetching) begin
        if (imem_ack) begin
          m_fetching = 0; m_holding = 1; m_ir = imem_rdata; m_illegal = 0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
          if (imem_rdata[15:11] > 5'd23 || imem_rdata[15:11] == 5'd17 ||
              imem_rdata[15:11] == 5'd18) begin
            m_ir[15:11] = 5'b11111; m_illegal = 1;
          end
`endif
        end else if (m_age == TO) begin
          m_err = 1; m_age = 0;
        end else begin
          m_age++;
        end
      end else if (run) begin
        m_fetching = 1; m_addr = pc; m_age = 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("cmp_req",   imem_req,  m_fetching);
    chk("cmp_addr",  imem_addr, m_addr);
    chk("cmp_valid", ir_valid,  m_holding);
    chk("cmp_busy",  busy,      m_fetching | m_holding);
    chk("cmp_err",   fetch_err, m_err);
    chk("cmp_opc",   OPCODE,    m_holding ? m_ir[15:11] : 5'b11111);
    chk("cmp_flag",  flagbit,   m_holding ? m_ir[10] : 1'b0);
    chk("cmp_imm",   imm,       m_holding ? m_ir[9:0] : 10'h0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    chk("cmp_ill",   illegal_op, m_holding & m_illegal);
`endif
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; pc = '0; exec_done = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge CLK);
    chk("rst_opc",  OPCODE,   5'b11111);
    chk("rst_busy", busy,     1'b0);
    chk("rst_req",  imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0);

    // Ack in the request cycle
    reset_n = 1'b1; run = 1'b1; pc = 16'h0040;
    @(negedge CLK);
    chk("t1_req",  imem_req,  1'b1);
    chk("t1_addr", imem_addr, 16'h0040);
    imem_ack = 1'b1; imem_rdata = 16'h5405;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("t1_valid", ir_valid, 1'b1);
    chk("t1_opc",   OPCODE,   5'b01010);
    chk("t1_flag",  flagbit,  1'b1);
    chk("t1_imm",   imm,      10'h005);

    // Ack delayed 3 cycles; pc moves and run drops during the wait
    exec_done = 1'b1; pc = 16'h0040;
    @(negedge CLK);
    exec_done = 1'b0;
    chk("t2_valid", ir_valid, 1'b0);
    chk("t2_req1",  imem_req, 1'b1);
    pc = 16'h0099; run = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      @(negedge CLK);
      chk("t2_req",  imem_req,  1'b1);
      chk("t2_addr", imem_addr, 16'h0040);
    end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("t2_valid", ir_valid, 1'b1);
    chk("t2_noreq", imem_req, 1'b0);
    chk("t2_opc",   OPCODE,   5'b00010);
    chk("t2_imm",   imm,      10'h234);

    // Hold without exec_done, then finish with run low
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t4_opc",   OPCODE,   5'b00010);
      chk("t4_valid", ir_valid, 1'b1);
    end
    exec_done = 1'b1;
    @(negedge CLK);
    exec_done = 1'b0;
    chk("t4_valid", ir_valid, 1'b0);
    chk("t4_opc",   OPCODE,   5'b11111);
    chk("t4_busy",  busy,     1'b0);

    // Timeout: 1 REQ + 15 WAIT cycles, error shows on the retry cycle
    run = 1'b1; pc = 16'h0100;
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      chk("t3_err",  fetch_err, 32'(i == 17));
      chk("t3_req",  imem_req,  1'b1);
      chk("t3_addr", imem_addr, 16'h0100);
    end
    imem_ack = 1'b1; imem_rdata = 16'hF800;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("t3_err0",  fetch_err, 1'b0);
    chk("t6_valid", ir_valid,  1'b1);
    chk("t6_opc",   OPCODE,    5'b11111);
    chk("t6_imm",   imm,       10'h0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    chk("t6_ill",   illegal_op, 1'b1);
`endif

    // Reset during wait; later ack ignored
    exec_done = 1'b1; pc = 16'h0200;
    @(negedge CLK);
    exec_done = 1'b0;
    chk("t5_req",  imem_req,  1'b1);
    chk("t5_addr", imem_addr, 16'h0200);
    @(negedge CLK);
    chk("t5_wait", imem_req, 1'b1);
    reset_n = 1'b0;
    @(negedge CLK);
    chk("t5_req0",  imem_req,  1'b0);
    chk("t5_valid", ir_valid,  1'b0);
    chk("t5_busy",  busy,      1'b0);
    chk("t5_addr0", imem_addr, 16'h0);
    reset_n = 1'b1; run = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h5405;
    @(negedge CLK);
    chk("t5_ign_valid", ir_valid, 1'b0);
    chk("t5_ign_opc",   OPCODE,   5'b11111);
    imem_ack = 1'b0;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
